visual_wave_capture: RTL and testbench

Triggered, double-buffered oscilloscope capture for the VGA wave display. Sits downstream of the ADC reader and input-level reduction, in parallel with the peak holder. It consumes the per-sample audio stream and waits for a level crossing. It then records one screen-width of samples into a back bank and swaps that bank to the pixel-read side only at a vertical-sync edge, so the wave trace never tears.

---
 rtl/visual_wave_capture_if.sv | 27 ++
 rtl/visual_wave_capture.sv | 111 +++++++++++
 tb/tb_visual_wave_capture.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/visual_wave_capture_if.sv
// visual_wave_capture_if: sample stream, trigger controls, frame sync and display read port
// master drives iSample/iSampleValid/iTrigLevel/iTrigSlope/iFreeze/iFrameSync/iRdAddr;
// slave returns oRdData/oReady/oTriggered/oBankSel/oState.
interface visual_wave_capture_if #(
    parameter int WS = 16
);
    logic signed [WS-1:0] iSample;
    logic                 iSampleValid;
    logic signed [WS-1:0] iTrigLevel;
    logic                 iTrigSlope;
    logic                 iFreeze;
    logic                 iFrameSync;
    logic [9:0]           iRdAddr;
    logic signed [WS-1:0] oRdData;
    logic                 oReady;
    logic                 oTriggered;
    logic                 oBankSel;
    logic [1:0]           oState;
    modport master (
        output iSample, iSampleValid, iTrigLevel, iTrigSlope, iFreeze, iFrameSync, iRdAddr,
        input  oRdData, oReady, oTriggered, oBankSel, oState
    );
    modport slave (
        input  iSample, iSampleValid, iTrigLevel, iTrigSlope, iFreeze, iFrameSync, iRdAddr,
        output oRdData, oReady, oTriggered, oBankSel, oState
    );
endinterface

// File: rtl/visual_wave_capture.sv
// visual_wave_capture: triggered, double-buffered scope capture swapped on vsync falling edge
// Ports: iCLK clock, iRST_N async active-low reset, bus (slave) carrying the sample stream,
// trigger/freeze/frame-sync controls, display read port and status (ready/triggered/bank/state).
module visual_wave_capture #(
    parameter int DEPTH        = 640,
    parameter int WS           = 16,
    parameter int TRIG_TIMEOUT = 2048
) (
    input logic                  iCLK,
    input logic                  iRST_N,
    visual_wave_capture_if.slave bus
);
    localparam int              CW       = $clog2(TRIG_TIMEOUT + 1);
    localparam logic [9:0]      LAST     = 10'(DEPTH - 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TRIG_TIMEOUT - 1);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;
    state_t               state_q, state_d;
    logic                 bank_q, bank_d;
    logic                 ready_q, ready_d;
    logic                 trig_out_q, trig_out_d;
    logic                 trig_flag_q, trig_flag_d;
    logic                 fs_prev_q;
    logic [9:0]           wr_addr_q, wr_addr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [WS-1:0] prev_q, prev_d;
    logic signed [WS-1:0] rd_data_q, rd_data_d;
    logic signed [WS-1:0] mem [2][DEPTH];
    logic                 we, hit, fs_fall;
    logic [9:0]           waddr;
    always_comb begin
        fs_fall     = fs_prev_q & ~bus.iFrameSync;
        hit         = bus.iTrigSlope ? (prev_q < bus.iTrigLevel && bus.iSample >= bus.iTrigLevel)
                                     : (prev_q > bus.iTrigLevel && bus.iSample <= bus.iTrigLevel);
        state_d     = state_q;
        bank_d      = bank_q;
        ready_d     = ready_q;
        trig_out_d  = trig_out_q;
        trig_flag_d = trig_flag_q;
        wr_addr_d   = wr_addr_q;
        cnt_d       = cnt_q;
        prev_d      = bus.iSampleValid ? bus.iSample : prev_q;
        we          = 1'b0;
        waddr       = wr_addr_q;
        case (state_q)
            IDLE: if (bus.iSampleValid) begin
                state_d = ARMED;
                cnt_d   = '0;
            end
            ARMED: if (bus.iSampleValid) begin
                // the trigger (or timeout) sample itself is the first word of the capture
                if (hit || cnt_q == CNT_LAST) begin
                    we          = 1'b1;
                    waddr       = '0;
                    wr_addr_d   = 10'd1;
                    trig_flag_d = hit;
                    state_d     = CAPTURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAPTURE: if (bus.iSampleValid) begin
                we        = 1'b1;
                wr_addr_d = (wr_addr_q == LAST) ? '0 : wr_addr_q + 1'b1;
                state_d   = (wr_addr_q == LAST) ? DONE : CAPTURE;
            end
            DONE: if (fs_fall && !bus.iFreeze) begin
                bank_d     = ~bank_q;
                trig_out_d = trig_flag_q;
                ready_d    = 1'b1;
                cnt_d      = '0;
                state_d    = ARMED;
            end
            default: ;
        endcase
        rd_data_d = (ready_q && bus.iRdAddr <= LAST) ? mem[bank_q][bus.iRdAddr] : '0;
    end
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= IDLE;
            bank_q      <= 1'b0;
            ready_q     <= 1'b0;
            trig_out_q  <= 1'b0;
            trig_flag_q <= 1'b0;
            fs_prev_q   <= 1'b1;
            wr_addr_q   <= '0;
            cnt_q       <= '0;
            prev_q      <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            ready_q     <= ready_d;
            trig_out_q  <= trig_out_d;
            trig_flag_q <= trig_flag_d;
            fs_prev_q   <= bus.iFrameSync;
            wr_addr_q   <= wr_addr_d;
            cnt_q       <= cnt_d;
            prev_q      <= prev_d;
            rd_data_q   <= rd_data_d;
        end
    end
    // capture always lands in the bank not being displayed
    always_ff @(posedge iCLK) begin
        if (we) mem[~bank_q][waddr] <= bus.iSample;
    end
    assign bus.oRdData    = rd_data_q;
    assign bus.oReady     = ready_q;
    assign bus.oTriggered = trig_out_q;
    assign bus.oBankSel   = bank_q;
    assign bus.oState     = state_q;
endmodule

// File: tb/tb_visual_wave_capture.sv
// tb_visual_wave_capture: directed tables plus randomized stream against a queue-based capture model
module tb_visual_wave_capture;
    localparam int DEPTH = 640;
    localparam int WS    = 16;
    localparam int TO    = 2048;
    typedef struct {
        logic [9:0] addr;
        int         exp;
    } rd_vec_t;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    visual_wave_capture_if #(.WS(WS)) bus ();
    visual_wave_capture #(.DEPTH(DEPTH), .WS(WS), .TRIG_TIMEOUT(TO)) dut (
        .iCLK  (clk),
        .iRST_N(rst_n),
        .bus   (bus)
    );
    int checks = 0;
    int passed = 0;
    bit m_started, m_ready, m_trig, m_bank, m_flag, m_prev_fs;
    int m_prev, m_armed_n;
    int cap[$];
    int disp[DEPTH];
    rd_vec_t rise_tab[6];
    rd_vec_t to_tab[5];
    rd_vec_t fall_tab[5];
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask
    function automatic bit crosses(input int p, input int c, input int l, input bit rising);
        return rising ? (p < l && c >= l) : (p > l && c <= l);
    endfunction
    function automatic int m_state();
        if (!m_started) return 0;
        if (cap.size() == 0) return 1;
        if (cap.size() < DEPTH) return 2;
        return 3;
    endfunction
    task automatic model_reset();
        m_started = 0; m_ready = 0; m_trig = 0; m_bank = 0; m_flag = 0; m_prev_fs = 1;
        m_prev = 0; m_armed_n = 0;
        cap.delete();
    endtask
    task automatic model_step(input bit v, input int s, input bit fs, input bit frz, input int lvl, input bit rise);
        bit fall;
        int n;
        fall = m_prev_fs && !fs;
        n = cap.size();
        if (!m_started) m_started = v;
        else if (n == 0) begin
            if (v) begin
                m_armed_n++;
                if (crosses(m_prev, s, lvl, rise) || m_armed_n == TO) begin
                    m_flag = crosses(m_prev, s, lvl, rise);
                    cap.push_back(s);
                end
            end
        end else if (n < DEPTH) begin
            if (v) cap.push_back(s);
        end else if (fall && !frz) begin
            for (int i = 0; i < DEPTH; i++) disp[i] = cap[i];
            m_ready = 1;
            m_trig = m_flag;
            m_bank = !m_bank;
            m_armed_n = 0;
            cap.delete();
        end
        if (v) m_prev = s;
        m_prev_fs = fs;
    endtask
    task automatic tick(input bit v, input int s, input bit fs, input bit frz, input logic [9:0] a);
        int exp_rd;
        bus.iSampleValid = v;
        bus.iSample      = WS'(s);
        bus.iFrameSync   = fs;
        bus.iFreeze      = frz;
        bus.iRdAddr      = a;
        exp_rd = (m_ready && a < DEPTH) ? disp[a] : 0;
        if (rst_n) model_step(v, s, fs, frz, int'(bus.iTrigLevel), bus.iTrigSlope);
        @(posedge clk);
        #1;
        chk("state", int'(bus.oState), m_state());
        chk("bank", int'(bus.oBankSel), int'(m_bank));
        chk("ready", int'(bus.oReady), int'(m_ready));
        chk("triggered", int'(bus.oTriggered), int'(m_trig));
        chk("rd_data", int'(bus.oRdData), exp_rd);
    endtask
    initial begin
        rise_tab = '{'{10'd0, 0}, '{10'd1, 1}, '{10'd639, 639}, '{10'd320, 320}, '{10'd640, 0}, '{10'd700, 0}};
        to_tab   = '{'{10'd0, 100}, '{10'd1, 100}, '{10'd639, 100}, '{10'd333, 100}, '{10'd1023, 0}};
        fall_tab = '{'{10'd0, 0}, '{10'd1, -1}, '{10'd2, -2}, '{10'd639, -639}, '{10'd700, 0}};
        bus.iSample = '0; bus.iSampleValid = 0; bus.iTrigLevel = '0; bus.iTrigSlope = 1;
        bus.iFreeze = 0; bus.iFrameSync = 1; bus.iRdAddr = '0;
        model_reset();
        repeat (3) tick(0, 0, 1, 0, 10'd5);
        chk("reset_state", int'(bus.oState), 0);
        chk("reset_ready", int'(bus.oReady), 0);
        chk("reset_rd", int'(bus.oRdData), 0);
        rst_n = 1;
        tick(1, -100, 1, 0, 0);
        chk("idle_to_armed", int'(bus.oState), 1);
        for (int v = -99; v <= 639; v++) tick(1, v, 1, 0, 0);
        chk("rise_done", int'(bus.oState), 3);
        tick(0, 0, 0, 0, 0);
        chk("rise_bank", int'(bus.oBankSel), 1);
        chk("rise_trig", int'(bus.oTriggered), 1);
        tick(0, 0, 1, 0, 0);
        foreach (rise_tab[i]) begin
            tick(0, 0, 1, 0, rise_tab[i].addr);
            chk("rise_rd", int'(bus.oRdData), rise_tab[i].exp);
        end
        bus.iTrigLevel = 16'sd1000;
        repeat (TO - 1) tick(1, 100, 1, 0, 0);
        chk("to_armed", int'(bus.oState), 1);
        tick(1, 100, 1, 0, 0);
        chk("to_capture", int'(bus.oState), 2);
        repeat (DEPTH - 1) tick(1, 100, 1, 0, 0);
        chk("to_done", int'(bus.oState), 3);
        tick(0, 0, 0, 0, 0);
        chk("to_trig", int'(bus.oTriggered), 0);
        chk("to_bank", int'(bus.oBankSel), 0);
        tick(0, 0, 1, 0, 0);
        foreach (to_tab[i]) begin
            tick(0, 0, 1, 0, to_tab[i].addr);
            chk("to_rd", int'(bus.oRdData), to_tab[i].exp);
        end
        bus.iTrigSlope = 0;
        bus.iTrigLevel = '0;
        for (int v = 50; v >= -639; v--) tick(1, v, 1, 0, 0);
        chk("fall_done", int'(bus.oState), 3);
        for (int k = 0; k < 3; k++) begin
            tick(0, 0, 0, 1, 0);
            chk("frz_state", int'(bus.oState), 3);
            chk("frz_bank", int'(bus.oBankSel), 0);
            tick(0, 0, 1, 1, 0);
        end
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 0, 0, 0);
        chk("frz_swap_bank", int'(bus.oBankSel), 1);
        chk("frz_swap_state", int'(bus.oState), 1);
        tick(0, 0, 1, 0, 0);
        foreach (fall_tab[i]) begin
            tick(0, 0, 1, 0, fall_tab[i].addr);
            chk("fall_rd", int'(bus.oRdData), fall_tab[i].exp);
        end
        bus.iTrigSlope = 1;
        for (int v = -5; v < 300; v++) tick(1, v, 1, 0, 10'd1);
        chk("mid_capture", int'(bus.oState), 2);
        chk("mid_ready", int'(bus.oReady), 1);
        rst_n = 0;
        #1;
        chk("async_state", int'(bus.oState), 0);
        chk("async_ready", int'(bus.oReady), 0);
        chk("async_bank", int'(bus.oBankSel), 0);
        chk("async_trig", int'(bus.oTriggered), 0);
        chk("async_rd", int'(bus.oRdData), 0);
        model_reset();
        tick(1, 7, 1, 0, 10'd1);
        rst_n = 1;
        tick(0, 0, 1, 0, 10'd700);
        chk("oor_rd", int'(bus.oRdData), 0);
        for (int c = 0; c < 20000; c++) begin
            if (c % 4000 == 0) begin
                bus.iTrigSlope = 1'($urandom_range(0, 1));
                bus.iTrigLevel = ((c / 4000) % 3 == 2) ? 16'sd30000 : WS'(int'($urandom_range(0, 100)) - 50);
            end
            tick($urandom_range(0, 9) < 7, int'($urandom_range(0, 400)) - 200, (c % 900) >= 5,
                 ((c / 1700) % 5) == 4, 10'($urandom_range(0, 700)));
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
